psola_playback: RTL

// Reader/consumer for the PSOLA output buffer. Once the overlap-add engine reports a finished frame
// (window_len + valid pulse), this block streams that frame out of the processed-sample BRAM.
// It emits one sample per sample_tick_in as signed 16-bit PCM.
// It zeroes each location after reading it, so the next accumulation starts clean.
// The buffer is ping-pong: bank_sel_out tells the PSOLA writer which bank it owns.

---
 rtl/psola_pkg.sv | 22 ++
 rtl/fx_to_pcm.sv | 30 +++
 rtl/pipeline.sv | 42 ++++
 rtl/psola_playback.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/psola_pkg.sv
// Shared types and constants for the PSOLA playback reader.
package psola_pkg;

    localparam int MAX_EXTENDED  = 2200;
    localparam int FRACTION_BITS = 14;
    localparam int BRAM_LATENCY  = 2;
    localparam int AW            = $clog2(MAX_EXTENDED);
    localparam int LEN_W         = 12;

    typedef enum logic {IDLE, PLAY} pb_state_t;

    typedef logic signed [31:0] acc_t;

    // Limit a reported frame length to what the buffer can actually hold.
    function automatic logic [AW-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (int'(len) > MAX_EXTENDED) begin
            return AW'(MAX_EXTENDED);
        end
        return AW'(len);
    endfunction

endpackage

// File: rtl/fx_to_pcm.sv
// Fixed-point accumulator word to 16-bit PCM: round half up, then saturate.
module fx_to_pcm
    import psola_pkg::*;
#(
    parameter int F = FRACTION_BITS
) (
    input  acc_t               acc,
    output logic signed [15:0] pcm
);

    localparam logic signed [32:0] HALF = 33'sd1 <<< (F - 1);

    logic signed [32:0]  rounded;
    logic signed [32-F:0] shifted;

    // Widen by one bit so adding the half LSB can never wrap.
    always_comb begin
        // NOTE: every path assigns every output, so no latch is inferred.
        rounded = $signed({acc[31], acc}) + HALF;
        shifted = rounded[32:F];
        if (shifted > 32767) begin
            pcm = 16'sh7FFF;
        end else if (shifted < -32768) begin
            pcm = 16'sh8000;
        end else begin
            pcm = shifted[15:0];
        end
    end

endmodule

// File: rtl/pipeline.sv
// Fixed-depth delay line: a valid bit plus a payload, shifted once per clock.
module pipeline #(
    parameter int STAGES = 2,
    parameter int W      = 8
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         d_valid,
    input  logic [W-1:0] d_data,
    output logic         q_valid,
    output logic [W-1:0] q_data
);

    logic [STAGES-1:0] valid_q;
    logic [W-1:0]      data_q [STAGES];

    // Valid chain: cleared by reset so nothing in flight survives it.
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state is updated with <= so every stage samples the pre-edge value.
        if (!rst_in) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= d_valid;
            for (int i = 1; i < STAGES; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // Payload chain: only meaningful when qualified by valid.
    always_ff @(posedge clk_in) begin
        // NOTE: payload registers carry no reset; the valid chain alone decides whether they matter.
        data_q[0] <= d_data;
        for (int i = 1; i < STAGES; i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    assign q_valid = valid_q[STAGES-1];
    assign q_data  = data_q[STAGES-1];

endmodule

// File: rtl/psola_playback.sv
// Streams completed PSOLA frames out of the ping-pong output BRAM, one
// sample per audio tick, zeroing each word once it has been played.
module psola_playback
    import psola_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [LEN_W-1:0]   window_len_in,
    input  logic               window_len_valid_in,
    input  logic               sample_tick_in,
    output logic               bank_sel_out,
    output logic [AW:0]        rd_addr_out,
    output logic               rd_en_out,
    input  acc_t               rd_data_in,
    output logic [AW:0]        clr_addr_out,
    output logic               clr_we_out,
    output logic signed [15:0] audio_out,
    output logic               audio_valid_out,
    output logic               busy_out,
    output logic               underrun_out,
    output logic               overrun_out
);

    localparam int CW = $clog2(BRAM_LATENCY + 1);

    pb_state_t      state;
    logic [AW-1:0]  ptr, len, pend_len;
    logic           pend_valid;
    logic [CW-1:0]  flight_cnt;
    logic           flight_play;

    logic [AW-1:0]  frame_len, eff_ptr, eff_len;
    logic           frame_ok, accept, play_frame, in_flight;
    logic           tick_ok, issue, last, rd_bank;
    logic [AW:0]    rd_addr;

    logic           pipe_valid;
    logic [AW+1:0]  pipe_data;
    logic           pipe_play;
    logic [AW:0]    pipe_addr;
    logic signed [15:0] pcm;

    // A frame accepted in IDLE is usable by a tick in the same cycle, so the
    // read address is formed from the values the FSM is about to latch.
    always_comb begin
        frame_len  = clamp_len(window_len_in);
        frame_ok   = window_len_valid_in && (frame_len != '0);
        accept     = frame_ok && (state == IDLE);
        play_frame = frame_ok && (state == PLAY);
        in_flight  = (flight_cnt != '0);
        eff_ptr    = accept ? '0 : ptr;
        eff_len    = accept ? frame_len : len;
        rd_bank    = accept ? bank_sel_out : ~bank_sel_out;
        tick_ok    = rst_in && sample_tick_in && !in_flight;
        issue      = tick_ok && ((state == PLAY) || accept);
        last       = issue && ((eff_ptr + AW'(1)) == eff_len);
        rd_addr    = {rd_bank, eff_ptr};
    end

    assign rd_en_out   = issue;
    assign rd_addr_out = issue ? rd_addr : '0;

    // Reads carry their own bank and a play/idle flag, so a bank flip on
    // restart cannot corrupt samples still in flight.
    pipeline #(
        .STAGES (BRAM_LATENCY),
        .W      (AW + 2)
    ) u_rd_pipe (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .d_valid (tick_ok),
        .d_data  ({issue, rd_addr}),
        .q_valid (pipe_valid),
        .q_data  (pipe_data)
    );

    assign pipe_play = pipe_data[AW+1];
    assign pipe_addr = pipe_data[AW:0];

    fx_to_pcm #(.F(FRACTION_BITS)) u_fx_to_pcm (
        .acc (rd_data_in),
        .pcm (pcm)
    );

    // Playback FSM: frame accept, pointer walk, pending slot and sticky flags.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state        <= IDLE;
            ptr          <= '0;
            len          <= '0;
            pend_valid   <= 1'b0;
            pend_len     <= '0;
            bank_sel_out <= 1'b0;
            flight_cnt   <= '0;
            flight_play  <= 1'b0;
            underrun_out <= 1'b0;
            overrun_out  <= 1'b0;
        end else begin
            if (tick_ok) begin
                flight_cnt  <= CW'(BRAM_LATENCY);
                flight_play <= issue;
            end else if (in_flight) begin
                flight_cnt <= flight_cnt - CW'(1);
            end

            if (sample_tick_in && in_flight) begin
                overrun_out <= 1'b1;
            end
            if (tick_ok && !issue) begin
                underrun_out <= 1'b1;
            end

            if (accept) begin
                state        <= PLAY;
                len          <= frame_len;
                ptr          <= '0;
                bank_sel_out <= ~bank_sel_out;
            end

            if (issue) begin
                ptr <= eff_ptr + AW'(1);
            end

            if (last) begin
                if (pend_valid || play_frame) begin
                    len          <= pend_valid ? pend_len : frame_len;
                    ptr          <= '0;
                    bank_sel_out <= ~bank_sel_out;
                    pend_valid   <= pend_valid && play_frame;
                    pend_len     <= frame_len;
                end else begin
                    state <= IDLE;
                end
            end else if (play_frame) begin
                pend_valid <= 1'b1;
                pend_len   <= frame_len;
                if (pend_valid) begin
                    overrun_out <= 1'b1;
                end
            end
        end
    end

    // Output stage: register the converted sample and the matching clear.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            audio_out       <= '0;
            audio_valid_out <= 1'b0;
            clr_we_out      <= 1'b0;
            clr_addr_out    <= '0;
        end else begin
            audio_valid_out <= pipe_valid;
            clr_we_out      <= pipe_valid && pipe_play;
            if (pipe_valid) begin
                audio_out <= pipe_play ? pcm : 16'sd0;
            end
            if (pipe_valid && pipe_play) begin
                clr_addr_out <= pipe_addr;
            end
        end
    end

    assign busy_out = (state == PLAY) || (in_flight && flight_play) || clr_we_out;

endmodule
